ddr_frame_writer: RTL and testbench

//  Parametrised successor to the render-side DDR2 port controller. Accepts a stream of
//  32-bit point words from a render engine, packs them into MIG write bursts of BURST_LEN

---
 rtl/ddr_frame_writer.sv | 91 +++++++++
 tb/tb_ddr_frame_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: packs render point words into MIG write bursts across a ring of frame buffers
module ddr_frame_writer #(
  parameter int          BURST_LEN    = 32,
  parameter int          FRAME_WORDS  = 307200,
  parameter int          NUM_BUFS     = 2,
  parameter logic [29:0] BASE_ADDR    = 30'h0,
  parameter logic [29:0] FRAME_STRIDE = 30'h12C000,
  parameter int          BUF_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_calib_done,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic             p0_wr_en,
  output logic [31:0]      p0_wr_data,
  output logic [3:0]       p0_wr_mask,
  input  logic             p0_wr_full,
  output logic             p0_cmd_en,
  output logic [2:0]       p0_cmd_instr,
  output logic [5:0]       p0_cmd_bl,
  output logic [29:0]      p0_cmd_byte_addr,
  input  logic             p0_cmd_full,
  output logic [BUF_W-1:0] display_buf,
  output logic             frame_done
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  typedef enum logic [1:0] {WAIT_CAL, FILL, ISSUE} state_t;
  state_t           state;
  logic [CW-1:0]    fill_cnt;
  logic [WW-1:0]    word_idx;
  logic [WW-1:0]    burst_start;
  logic [BUF_W-1:0] write_buf;
  logic [BUF_W-1:0] next_buf;
  logic             frame_end;
  logic             accept;
  logic             burst_full;
  logic             frame_full;
  // Input is only taken while filling a burst with room in both the burst and the MIG FIFO
  assign in_ready   = state == FILL && !p0_wr_full && fill_cnt < CW'(BURST_LEN);
  assign accept     = in_valid && in_ready;
  assign burst_full = fill_cnt == CW'(BURST_LEN - 1);
  assign frame_full = word_idx == WW'(FRAME_WORDS - 1);
  assign next_buf   = write_buf == BUF_W'(NUM_BUFS - 1) ? '0 : write_buf + BUF_W'(1);
  assign p0_wr_en   = accept;
  assign p0_wr_data = in_data;
  assign p0_wr_mask = '0;
  assign p0_cmd_en    = state == ISSUE && !p0_cmd_full;
  assign p0_cmd_instr = '0;
  assign p0_cmd_bl    = 6'(fill_cnt - CW'(1));
  assign p0_cmd_byte_addr = BASE_ADDR + 30'(write_buf) * FRAME_STRIDE + 30'({burst_start, 2'b00});
  // Burst/frame sequencing: fill a burst, issue its command once the data is pushed, rotate buffers at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_CAL;
      fill_cnt    <= '0;
      word_idx    <= '0;
      burst_start <= '0;
      frame_end   <= 1'b0;
      write_buf   <= BUF_W'(1 % NUM_BUFS);
      display_buf <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_CAL: state <= mem_calib_done ? FILL : WAIT_CAL;
        FILL: if (accept) begin
          fill_cnt  <= fill_cnt + CW'(1);
          word_idx  <= word_idx + WW'(1);
          frame_end <= in_last || frame_full;
          state     <= (in_last || frame_full || burst_full) ? ISSUE : FILL;
        end
        ISSUE: if (!p0_cmd_full) begin
          state       <= FILL;
          fill_cnt    <= '0;
          burst_start <= frame_end ? '0 : burst_start + WW'(fill_cnt);
          if (frame_end) begin
            display_buf <= write_buf;
            write_buf   <= next_buf;
            word_idx    <= '0;
            frame_done  <= 1'b1;
          end
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb_ddr_frame_writer: directed and randomized checks of ddr_frame_writer against a word-level model
module tb_ddr_frame_writer;
  localparam int BL = 4, FW = 6, NB = 2, BW = 2;
  localparam logic [29:0] BASE = 30'h0, STRIDE = 30'h100;
  logic clk = 0, reset = 1, mem_calib_done = 0, in_valid = 0, in_last = 0;
  logic p0_wr_full = 0, p0_cmd_full = 0;
  logic [31:0] in_data = 0;
  logic in_ready, p0_wr_en, p0_cmd_en, frame_done;
  logic [31:0] p0_wr_data;
  logic [3:0] p0_wr_mask;
  logic [2:0] p0_cmd_instr;
  logic [5:0] p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic [BW-1:0] display_buf;
  typedef struct {int bl; int addr; bit fe; int b;} cmd_t;
  cmd_t exp_q[$];
  cmd_t log_q[$];
  int checks = 0, failures = 0, m_pos = 0, m_wbuf = 1 % NB, m_dbuf = 0, n_acc = 0;
  bit fd_pend = 0, cal = 0;

  ddr_frame_writer #(.BURST_LEN(BL), .FRAME_WORDS(FW), .NUM_BUFS(NB), .BASE_ADDR(BASE),
                     .FRAME_STRIDE(STRIDE), .BUF_W(BW)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .p0_wr_en(p0_wr_en),
    .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask), .p0_wr_full(p0_wr_full),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
    .display_buf(display_buf), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pos = 0;
    m_wbuf = 1 % NB;
    m_dbuf = 0;
    fd_pend = 0;
  endtask

  // Mid-cycle observation: a word is burst-closing if it ends a BL-aligned group, the frame, or carries last
  task automatic sample();
    cmd_t e;
    bit acc;
    acc = in_valid && in_ready;
    chk("wr_en", p0_wr_en, acc);
    if (p0_wr_full) chk("ready_under_full", in_ready, 0);
    chk("frame_done", frame_done, fd_pend);
    chk("display_buf", display_buf, m_dbuf);
    fd_pend = 0;
    if (acc) begin
      n_acc++;
      chk("wr_data", p0_wr_data, in_data);
      chk("wr_mask", p0_wr_mask, 0);
      chk("accept_while_cmd_pending", exp_q.size(), 0);
      if (m_pos % BL == BL - 1 || m_pos == FW - 1 || in_last)
        exp_q.push_back('{m_pos % BL, BASE + m_wbuf * STRIDE + (m_pos - m_pos % BL) * 4,
                          (m_pos == FW - 1) || in_last, m_wbuf});
      if (m_pos == FW - 1 || in_last) begin
        m_pos = 0;
        m_wbuf = (m_wbuf + 1) % NB;
      end else m_pos++;
    end
    if (p0_cmd_en === 1'b1) begin
      chk("cmd_while_full", p0_cmd_full, 0);
      chk("cmd_instr", p0_cmd_instr, 0);
      chk("cmd_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cmd_bl", p0_cmd_bl, e.bl);
        chk("cmd_addr", p0_cmd_byte_addr, e.addr);
        log_q.push_back('{int'(p0_cmd_bl), int'(p0_cmd_byte_addr), e.fe, e.b});
        if (e.fe) begin
          fd_pend = 1;
          m_dbuf = e.b;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit l, input bit wf, input bit cf);
    @(posedge clk);
    #1;
    reset = r;
    mem_calib_done = cal;
    in_valid = v;
    in_last = l;
    p0_wr_full = wf;
    p0_cmd_full = cf;
    in_data = $urandom;
    @(negedge clk);
    sample();
    if (r) model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk_cmd(input string tag, input int k, input int bl, input int addr);
    chk({tag, "_bl"}, log_q[k].bl, bl);
    chk({tag, "_addr"}, log_q[k].addr, addr);
  endtask

  initial begin
    int s, base;
    repeat (2) @(posedge clk);
    repeat (3) cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("calib_ready", in_ready, 0);
      chk("calib_cmd", p0_cmd_en, 0);
    end
    cal = 1;
    cyc(0, 1, 0, 0, 0);
    chk("calib_edge_ready", in_ready, 0);
    cyc(0, 1, 0, 0, 0);
    chk("first_accept", p0_wr_en, 1);
    for (int i = 0; i < 80 && n_acc < 12; i++) cyc(0, 1, 0, 0, 0);
    idle(6);
    chk("two_frames_cmds", log_q.size(), 4);
    chk_cmd("f0_b0", 0, 3, 'h100);
    chk_cmd("f0_b1", 1, 1, 'h110);
    chk_cmd("f1_b0", 2, 3, 'h0);
    chk_cmd("f1_b1", 3, 1, 'h10);
    chk("display_after_f1", display_buf, 0);
    base = log_q.size();
    s = n_acc;
    for (int i = 0; i < 40 && n_acc < s + 3; i++) cyc(0, 1, n_acc == s + 2, 0, 0);
    idle(4);
    chk_cmd("last3", base, 2, 'h100);
    chk("display_after_last3", display_buf, 1);
    s = n_acc;
    for (int i = 0; i < 40 && n_acc < s + 4; i++) cyc(0, 1, 0, 0, 0);
    idle(4);
    chk_cmd("after_last3", base + 1, 3, 'h0);
    s = n_acc;
    for (int i = 0; i < 40 && n_acc < s + 1; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 1, 0);
      chk("wr_full_stall", in_ready, 0);
    end
    for (int i = 0; i < 40 && n_acc < s + 2; i++) cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("cmd_full_hold", p0_cmd_en, 0);
      chk("cmd_full_ready", in_ready, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("cmd_strobe", p0_cmd_en, 1);
    cyc(0, 0, 0, 0, 0);
    chk("cmd_single", p0_cmd_en, 0);
    chk_cmd("stalled", base + 2, 1, 'h10);
    chk("stall_words", n_acc, s + 2);
    s = n_acc;
    for (int i = 0; i < 40 && n_acc < s + 2; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("reset_no_cmd", p0_cmd_en, 0);
    end
    chk("reset_display", display_buf, 0);
    s = n_acc;
    for (int i = 0; i < 40 && n_acc < s + 4; i++) cyc(0, 1, 0, 0, 0);
    idle(4);
    chk_cmd("post_reset", base, 3, 'h100);
    s = n_acc;
    for (int i = 0; i < 4000 && n_acc < s + 400; i++)
      cyc(0, $urandom % 4 != 0, $urandom % 12 == 0, $urandom % 5 == 0, $urandom % 4 == 0);
    chk("rand_progress", n_acc >= s + 400, 1);
    s = n_acc;
    for (int i = 0; i < 60 && n_acc == s; i++) cyc(0, 1, 1, 0, 0);
    chk("flush_accept", n_acc, s + 1);
    idle(10);
    chk("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
